// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write arbiter: width defaults,
// the round-robin priority state and the per-cycle grant encoding.
package rf_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;

    // Which requester wins the next contested cycle.
    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } pri_t;

    // Outcome of arbitration in a single cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_A    = 2'd1,
        GNT_B    = 2'd2
    } gnt_t;

    // Select at most one requester; the priority state only matters on contention.
    function automatic gnt_t arbitrate(input logic a_valid,
                                       input logic b_valid,
                                       input pri_t pri);
        gnt_t gnt;
        gnt = GNT_NONE;
        if (a_valid && b_valid) begin
            gnt = (pri == PRI_A) ? GNT_A : GNT_B;
        end else if (a_valid) begin
            gnt = GNT_A;
        end else if (b_valid) begin
            gnt = GNT_B;
        end
        return gnt;
    endfunction

    // The requester just served loses priority; idle cycles keep the state.
    function automatic pri_t next_pri(input pri_t cur, input gnt_t gnt);
        pri_t nxt;
        nxt = cur;
        case (gnt)
            GNT_A:   nxt = PRI_B;
            GNT_B:   nxt = PRI_A;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/rf_fwd.sv
// Read-port bypass: returns the value sitting in the registered write stage
// when it targets the address being read, otherwise the raw register file data.
// The output is named fwd_do because 'do' is a reserved word.
module rf_fwd #(
    parameter int DATA_W = rf_pkg::DATA_W_DEF,
    parameter int ADDR_W = rf_pkg::ADDR_W_DEF
) (
    input  logic              we,
    input  logic [ADDR_W-1:0] ptr_w,
    input  logic [DATA_W-1:0] di,
    input  logic [ADDR_W-1:0] ptr,
    input  logic [DATA_W-1:0] rf_do,
    output logic [DATA_W-1:0] fwd_do
);

    logic hit;

    // Only the write stage is considered; ungranted requests never bypass.
    assign hit    = we && (ptr_w == ptr);
    assign fwd_do = hit ? di : rf_do;

endmodule

// File: rtl/rf_wr_arb.sv
// Two-requester write arbiter in front of a register file write port.
// A (ALU writeback) and B (load writeback) share one registered write stage
// with round-robin priority on contention; both read ports are bypassed from
// that stage so consumers see a write in the cycle it is presented.
module rf_wr_arb
    import rf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    // requester A: ALU writeback
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_ptr,
    input  logic [DATA_W-1:0] a_di,
    output logic              a_ready,
    // requester B: load writeback
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_ptr,
    input  logic [DATA_W-1:0] b_di,
    output logic              b_ready,
    // register file write port
    output logic              we,
    output logic [ADDR_W-1:0] ptr_w,
    output logic [DATA_W-1:0] di,
    // register file read ports
    input  logic [ADDR_W-1:0] ptr_a,
    input  logic [ADDR_W-1:0] ptr_b,
    input  logic [DATA_W-1:0] rf_do_a,
    input  logic [DATA_W-1:0] rf_do_b,
    output logic [DATA_W-1:0] do_a,
    output logic [DATA_W-1:0] do_b
);

    pri_t pri;
    gnt_t gnt;

    // Combinational grant; nothing is accepted while reset is held.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        gnt     = GNT_NONE;
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!reset) begin
            gnt     = arbitrate(a_valid, b_valid, pri);
            a_ready = (gnt == GNT_A);
            b_ready = (gnt == GNT_B);
        end
    end

    // Registered write stage and priority update, one cycle after the transfer.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register here sampling
        // the pre-edge values, independent of statement order.
        if (reset) begin
            we    <= 1'b0;
            ptr_w <= '0;
            di    <= '0;
            pri   <= PRI_A;
        end else begin
            we  <= (gnt != GNT_NONE);
            pri <= next_pri(pri, gnt);
            case (gnt)
                GNT_A: begin
                    ptr_w <= a_ptr;
                    di    <= a_di;
                end
                GNT_B: begin
                    ptr_w <= b_ptr;
                    di    <= b_di;
                end
                default: begin
                    ptr_w <= ptr_w;
                    di    <= di;
                end
            endcase
        end
    end

    rf_fwd #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fwd_a (
        .we     (we),
        .ptr_w  (ptr_w),
        .di     (di),
        .ptr    (ptr_a),
        .rf_do  (rf_do_a),
        .fwd_do (do_a)
    );

    rf_fwd #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fwd_b (
        .we     (we),
        .ptr_w  (ptr_w),
        .di     (di),
        .ptr    (ptr_b),
        .rf_do  (rf_do_b),
        .fwd_do (do_b)
    );

endmodule

// File: tb/tb_rf_wr_arb.sv
// Directed and randomized bench for rf_wr_arb with a behavioural register file.
module tb_rf_wr_arb;

    logic       clk;
    logic       reset;
    logic       a_valid, b_valid;
    logic [3:0] a_ptr, b_ptr;
    logic [7:0] a_di, b_di;
    logic       a_ready, b_ready;
    logic       we;
    logic [3:0] ptr_w;
    logic [7:0] di;
    logic [3:0] ptr_a, ptr_b;
    logic [7:0] rf_do_a, rf_do_b;
    logic [7:0] do_a, do_b;

    logic [7:0] rf_model [16];

    int total;
    int bad;

    rf_wr_arb dut (
        .clk     (clk),
        .reset   (reset),
        .a_valid (a_valid),
        .a_ptr   (a_ptr),
        .a_di    (a_di),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_ptr   (b_ptr),
        .b_di    (b_di),
        .b_ready (b_ready),
        .we      (we),
        .ptr_w   (ptr_w),
        .di      (di),
        .ptr_a   (ptr_a),
        .ptr_b   (ptr_b),
        .rf_do_a (rf_do_a),
        .rf_do_b (rf_do_b),
        .do_a    (do_a),
        .do_b    (do_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register file: cleared (r6 preset to 0x66) on reset, written from the DUT port.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) rf_model[i] <= 8'h00;
            rf_model[6] <= 8'h66;
        end else if (we) begin
            rf_model[ptr_w] <= di;
        end
    end

    assign rf_do_a = rf_model[ptr_a];
    assign rf_do_b = rf_model[ptr_b];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset   = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset   = 1'b1;
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_ptr   = 4'd2;
        a_di    = 8'h12;
        b_ptr   = 4'd3;
        b_di    = 8'h34;
        ptr_a   = 4'd0;
        ptr_b   = 4'd0;
        tick();
        tick();
        total++; if (we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", we); end
        total++; if (ptr_w !== 4'd0) begin bad++; $display("FAIL reset_ptr_w: got %h want 0", ptr_w); end
        total++; if (di !== 8'h00) begin bad++; $display("FAIL reset_di: got %h want 00", di); end
        total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL reset_a_ready: got %b want 0", a_ready); end
        total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL reset_b_ready: got %b want 0", b_ready); end
        a_valid = 1'b0;
        b_valid = 1'b0;
        reset   = 1'b0;
    endtask

    task automatic test_a_only;
        a_valid = 1'b1;
        a_ptr   = 4'd3;
        a_di    = 8'h5A;
        #1;
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL aonly_a_ready: got %b want 1", a_ready); end
        total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL aonly_b_ready: got %b want 0", b_ready); end
        tick();
        a_valid = 1'b0;
        total++; if (we !== 1'b1) begin bad++; $display("FAIL aonly_we: got %b want 1", we); end
        total++; if (ptr_w !== 4'd3) begin bad++; $display("FAIL aonly_ptr_w: got %h want 3", ptr_w); end
        total++; if (di !== 8'h5A) begin bad++; $display("FAIL aonly_di: got %h want 5a", di); end
        tick();
        total++; if (we !== 1'b0) begin bad++; $display("FAIL aonly_we_idle: got %b want 0", we); end
        total++; if (ptr_w !== 4'd3) begin bad++; $display("FAIL aonly_ptr_hold: got %h want 3", ptr_w); end
        total++; if (di !== 8'h5A) begin bad++; $display("FAIL aonly_di_hold: got %h want 5a", di); end
    endtask

    task automatic test_alternate;
        logic       exp_a;
        logic [3:0] exp_ptr;
        logic [7:0] exp_di;
        do_reset();
        a_valid = 1'b1; a_ptr = 4'd1; a_di = 8'h11;
        b_valid = 1'b1; b_ptr = 4'd2; b_di = 8'h22;
        for (int i = 0; i < 4; i++) begin
            exp_a   = (i % 2 == 0);
            exp_ptr = exp_a ? 4'd1 : 4'd2;
            exp_di  = exp_a ? 8'h11 : 8'h22;
            #1;
            total++; if (a_ready !== exp_a) begin bad++; $display("FAIL alt_a_ready[%0d]: got %b want %b", i, a_ready, exp_a); end
            total++; if (b_ready !== !exp_a) begin bad++; $display("FAIL alt_b_ready[%0d]: got %b want %b", i, b_ready, !exp_a); end
            tick();
            total++; if (we !== 1'b1) begin bad++; $display("FAIL alt_we[%0d]: got %b want 1", i, we); end
            total++; if (ptr_w !== exp_ptr) begin bad++; $display("FAIL alt_ptr_w[%0d]: got %h want %h", i, ptr_w, exp_ptr); end
            total++; if (di !== exp_di) begin bad++; $display("FAIL alt_di[%0d]: got %h want %h", i, di, exp_di); end
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic test_collision;
        do_reset();
        // One lone A grant moves priority to B.
        a_valid = 1'b1; a_ptr = 4'd0; a_di = 8'h01;
        tick();
        a_valid = 1'b1; a_ptr = 4'd5; a_di = 8'hAA;
        b_valid = 1'b1; b_ptr = 4'd5; b_di = 8'hBB;
        #1;
        total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL coll_b_ready: got %b want 1", b_ready); end
        total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL coll_a_ready: got %b want 0", a_ready); end
        tick();
        b_valid = 1'b0;
        total++; if (ptr_w !== 4'd5) begin bad++; $display("FAIL coll_first_ptr: got %h want 5", ptr_w); end
        total++; if (di !== 8'hBB) begin bad++; $display("FAIL coll_first_di: got %h want bb", di); end
        #1;
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL coll_a_ready2: got %b want 1", a_ready); end
        tick();
        a_valid = 1'b0;
        total++; if (we !== 1'b1) begin bad++; $display("FAIL coll_second_we: got %b want 1", we); end
        total++; if (di !== 8'hAA) begin bad++; $display("FAIL coll_second_di: got %h want aa", di); end
        tick();
        ptr_a = 4'd5;
        #1;
        total++; if (we !== 1'b0) begin bad++; $display("FAIL coll_we_idle: got %b want 0", we); end
        total++; if (do_a !== 8'hAA) begin bad++; $display("FAIL coll_read_r5: got %h want aa", do_a); end
    endtask

    task automatic test_forwarding;
        do_reset();
        a_valid = 1'b1; a_ptr = 4'd7; a_di = 8'h3C;
        ptr_a = 4'd7;
        ptr_b = 4'd6;
        #1;
        // Pending but not yet granted: no bypass.
        total++; if (do_a !== 8'h00) begin bad++; $display("FAIL fwd_pending: got %h want 00", do_a); end
        tick();
        a_valid = 1'b0;
        // Lone B request to r7 pending while A's write sits in the stage.
        b_valid = 1'b1; b_ptr = 4'd7; b_di = 8'hE1;
        #1;
        total++; if (we !== 1'b1) begin bad++; $display("FAIL fwd_we: got %b want 1", we); end
        total++; if (do_a !== 8'h3C) begin bad++; $display("FAIL fwd_do_a: got %h want 3c", do_a); end
        total++; if (do_b !== 8'h66) begin bad++; $display("FAIL fwd_do_b_raw: got %h want 66", do_b); end
        ptr_b = 4'd7;
        ptr_a = 4'd6;
        #1;
        total++; if (do_b !== 8'h3C) begin bad++; $display("FAIL fwd_do_b_hit: got %h want 3c", do_b); end
        total++; if (do_a !== 8'h66) begin bad++; $display("FAIL fwd_do_a_miss: got %h want 66", do_a); end
        tick();
        b_valid = 1'b0;
        ptr_a = 4'd7;
        #1;
        total++; if (do_a !== 8'hE1) begin bad++; $display("FAIL fwd_b_stage: got %h want e1", do_a); end
        tick();
        ptr_a = 4'd6;
        #1;
        total++; if (do_a !== 8'h66) begin bad++; $display("FAIL fwd_idle_raw: got %h want 66", do_a); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        a_valid = 1'b1; a_ptr = 4'd4; a_di = 8'h99;
        tick();
        total++; if (we !== 1'b1) begin bad++; $display("FAIL mid_grant_we: got %b want 1", we); end
        reset   = 1'b1;
        a_valid = 1'b1; a_ptr = 4'd8; a_di = 8'h81;
        b_valid = 1'b1; b_ptr = 4'd9; b_di = 8'h92;
        #1;
        total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL mid_a_ready: got %b want 0", a_ready); end
        total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL mid_b_ready: got %b want 0", b_ready); end
        tick();
        total++; if (we !== 1'b0) begin bad++; $display("FAIL mid_we: got %b want 0", we); end
        total++; if (ptr_w !== 4'd0) begin bad++; $display("FAIL mid_ptr_w: got %h want 0", ptr_w); end
        reset = 1'b0;
        #1;
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL mid_release_a: got %b want 1", a_ready); end
        total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL mid_release_b: got %b want 0", b_ready); end
        tick();
        a_valid = 1'b0;
        total++; if (ptr_w !== 4'd8) begin bad++; $display("FAIL mid_release_ptr: got %h want 8", ptr_w); end
        total++; if (di !== 8'h81) begin bad++; $display("FAIL mid_release_di: got %h want 81", di); end
        tick();
        b_valid = 1'b0;
        total++; if (di !== 8'h92) begin bad++; $display("FAIL mid_then_b_di: got %h want 92", di); end
    endtask

    task automatic test_random;
        logic       pri_b;
        logic       eg_a, eg_b;
        logic [3:0] exp_ptr;
        logic [7:0] exp_di;
        int         grants;
        int         writes;
        do_reset();
        pri_b  = 1'b0;
        grants = 0;
        writes = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (!a_valid && $urandom_range(0, 2) != 0) begin
                a_valid = 1'b1;
                a_ptr   = 4'($urandom_range(0, 15));
                a_di    = 8'($urandom_range(0, 255));
            end
            if (!b_valid && $urandom_range(0, 2) != 0) begin
                b_valid = 1'b1;
                b_ptr   = 4'($urandom_range(0, 15));
                b_di    = 8'($urandom_range(0, 255));
            end
            #1;
            eg_a = a_valid && (!b_valid || !pri_b);
            eg_b = b_valid && (!a_valid || pri_b);
            total++; if (a_ready !== eg_a) begin bad++; $display("FAIL rnd_a_ready[%0d]: got %b want %b", cyc, a_ready, eg_a); end
            total++; if (b_ready !== eg_b) begin bad++; $display("FAIL rnd_b_ready[%0d]: got %b want %b", cyc, b_ready, eg_b); end
            exp_ptr = ptr_w;
            exp_di  = di;
            if (eg_a) begin
                exp_ptr = a_ptr; exp_di = a_di; pri_b = 1'b1; grants++;
            end else if (eg_b) begin
                exp_ptr = b_ptr; exp_di = b_di; pri_b = 1'b0; grants++;
            end
            tick();
            if (we === 1'b1) writes++;
            total++; if (we !== (eg_a || eg_b)) begin bad++; $display("FAIL rnd_we[%0d]: got %b want %b", cyc, we, eg_a || eg_b); end
            total++; if (ptr_w !== exp_ptr) begin bad++; $display("FAIL rnd_ptr_w[%0d]: got %h want %h", cyc, ptr_w, exp_ptr); end
            total++; if (di !== exp_di) begin bad++; $display("FAIL rnd_di[%0d]: got %h want %h", cyc, di, exp_di); end
            if (eg_a) a_valid = 1'b0;
            if (eg_b) b_valid = 1'b0;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        total++; if (writes !== grants) begin bad++; $display("FAIL rnd_write_count: got %0d want %0d", writes, grants); end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_ptr   = '0;
        b_ptr   = '0;
        a_di    = '0;
        b_di    = '0;
        ptr_a   = '0;
        ptr_b   = '0;
        test_reset();
        test_a_only();
        test_alternate();
        test_collision();
        test_forwarding();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_wr_arb.md
RF_WR_ARB -- requirements
Module: rf_wr_arb

Interface
REQ-001 Parameter DATA_W, default 8, register data width.
REQ-002 Parameter ADDR_W, default 4, register address width (16 entries).
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 a_valid / b_valid  in  1  requester A (ALU writeback) / B (load writeback) has a write pending.
REQ-006 a_ptr / b_ptr  in  ADDR_W  destination register of A / B.
REQ-007 a_di / b_di  in  DATA_W  write data of A / B.
REQ-008 a_ready / b_ready  out  1  combinational accept of A / B this cycle.
REQ-009 we  out  1  registered write enable to the register file.
REQ-010 ptr_w  out  ADDR_W  registered write address.
REQ-011 di  out  DATA_W  registered write data.
REQ-012 ptr_a / ptr_b  in  ADDR_W  read addresses presented to the register file.
REQ-013 rf_do_a / rf_do_b  in  DATA_W  raw read data returned by the register file.
REQ-014 do_a / do_b  out  DATA_W  forwarded read data for consumers.

Function
REQ-015 A transfer occurs on a requester when valid and ready are both 1 at a posedge.
REQ-016 At most one requester is granted per cycle; ready is 0 for any requester whose valid is 0.
REQ-017 Only one requester valid: that requester is granted.
REQ-018 Both requesters valid: the requester selected by the priority state is granted; the other sees ready=0 and keeps valid, ptr and di stable until granted.
REQ-019 The priority state has two values: PRI_A and PRI_B. A grant to A sets PRI_B, and a grant to B sets PRI_A. A cycle with no grant leaves the state unchanged.
REQ-020 A granted request drives we=1, ptr_w and di with the granted ptr and data exactly one cycle after the transfer. In a cycle with no grant, we=0 on the next cycle, and ptr_w and di hold their previous values.
REQ-021 Back-to-back grants are allowed every cycle. Sustained throughput is one write per cycle.
REQ-022 Both requesters valid with equal ptr: the arbitration rule is unchanged. The losing write lands one or more cycles later, so it is the final value.
REQ-023 Forwarding: when we=1 and ptr_w==ptr_a, do_a=di; otherwise do_a=rf_do_a. The same rule applies to do_b with ptr_b. Both paths are combinational.
REQ-024 Forwarding uses only the registered write stage. Requests that have not yet been granted are never forwarded.
REQ-025 No combinational path from any valid input to we, ptr_w or di.

Reset
REQ-026 While reset=1 at a posedge: we<=0, ptr_w<=0, di<=0, and the priority state goes to PRI_A.
REQ-027 While reset=1: a_ready=0 and b_ready=0. No transfer is counted during reset.
REQ-028 Reset asserted in the cycle after a grant: the pending write is dropped and we=0 on the following cycle.
REQ-029 In the first cycle after reset deasserts, arbitration resumes with PRI_A.

Structure
REQ-030 A shared package rf_pkg holds DATA_W/ADDR_W defaults and the priority-state enum (PRI_A, PRI_B).
REQ-031 Forwarding is one sub-module, rf_fwd, instantiated twice (port a, port b): inputs we, ptr_w, di, ptr, rf_do; output do.
REQ-032 rf_wr_arb connects directly to the register file's we/ptr_w/di write port with no additional glue.

Verification
REQ-033 Reset, then A only: a_valid=1, a_ptr=3, a_di=0x5A -> a_ready=1; next cycle we=1, ptr_w=3, di=0x5A; the cycle after, we=0.
REQ-034 Both requesters valid continuously for 4 cycles from reset, a_di=0x11, b_di=0x22, ptrs 1 and 2 -> grants A,B,A,B; ptr_w sequence 1,2,1,2 one cycle later.
REQ-035 Same-address collision, both valid with ptr=5, PRI_B state, a_di=0xAA, b_di=0xBB -> B written first, A second; a read of r5 afterwards gives 0xAA.
REQ-036 Forwarding: we=1, ptr_w=7, di=0x3C, ptr_a=7, rf_do_a=0x00, ptr_b=6 -> do_a=0x3C, do_b=rf_do_b.
REQ-037 Reset mid-operation: grant A (ptr=4, 0x99), then assert reset the next cycle -> we=0, both ready=0; after release, a contested request is granted to A first.
REQ-038 Random valid traffic for 1000 cycles checked against a reference model -> every accepted write appears exactly once, in grant order, with no lost or duplicated writes.
